// File: rtl/tlb_8e_if.sv
// Request/response and page-table lookup signals of the eight-entry translation cache.
// The slave modport is the cache side; the master modport is the requester/page-table side.
interface tlb_8e_if;
  logic        REQ_VALID;
  logic [8:0]  REQ_VADDR;
  logic        REQ_READY;
  logic        RESP_VALID;
  logic [11:0] RESP_PADDR;
  logic        RESP_HIT;
  logic        FLUSH;
  logic        LOOKUP_RQST;
  logic [5:0]  LOOKUP_ADDR;
  logic        LOOKUP_COMPLETE;
  logic [11:0] LOOKUP_RETURN;

  modport slave (
    input  REQ_VALID, REQ_VADDR, FLUSH, LOOKUP_COMPLETE, LOOKUP_RETURN,
    output REQ_READY, RESP_VALID, RESP_PADDR, RESP_HIT, LOOKUP_RQST, LOOKUP_ADDR
  );

  modport master (
    output REQ_VALID, REQ_VADDR, FLUSH, LOOKUP_COMPLETE, LOOKUP_RETURN,
    input  REQ_READY, RESP_VALID, RESP_PADDR, RESP_HIT, LOOKUP_RQST, LOOKUP_ADDR
  );
endinterface

// File: rtl/tlb_8e.sv
// Fully associative translation cache (9-bit VA, 8-byte pages) with round-robin refill
// from the page table. Define TLB_STATS_EN to add saturating HIT_COUNT/MISS_COUNT outputs.
module tlb_8e #(
  parameter int NUM_ENTRIES = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  tlb_8e_if.slave     bus
`ifdef TLB_STATS_EN
  ,
  output logic [15:0] HIT_COUNT,
  output logic [15:0] MISS_COUNT
`endif
);

  localparam int PTR_W = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    MISS_REQ  = 2'd1,
    MISS_WAIT = 2'd2,
    RESP      = 2'd3
  } state_t;

  state_t                 state_reg;
  logic [NUM_ENTRIES-1:0] valid_reg;
  logic [5:0]             vpn_reg [NUM_ENTRIES];
  logic [8:0]             ppn_reg [NUM_ENTRIES];
  logic [PTR_W-1:0]       victim_ptr_reg;
  logic [8:0]             vaddr_reg;
  logic                   flush_seen_reg;
  logic                   resp_valid_reg;
  logic                   resp_hit_reg;
  logic [11:0]            resp_paddr_reg;
  logic                   lookup_rqst_reg;
  logic [5:0]             lookup_addr_reg;

  logic [NUM_ENTRIES-1:0] match;
  logic                   hit_any;
  logic [8:0]             hit_ppn;
  logic                   accept;
  logic                   fill;
  logic                   fill_keep;
  logic                   unused_return_bits;

  generate
    for (genvar gi = 0; gi < NUM_ENTRIES; gi++) begin : g_tag_cmp
      assign match[gi] = valid_reg[gi] && (vpn_reg[gi] == bus.REQ_VADDR[8:3]);
    end
  endgenerate

  // VPNs in valid entries are unique, so OR-ing the matching PPNs selects the single hit.
  always_comb begin
    hit_any = 1'b0;
    hit_ppn = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      if (match[i]) begin
        hit_any = 1'b1;
        hit_ppn = hit_ppn | ppn_reg[i];
      end
    end
  end

  assign bus.REQ_READY = rst_n && (state_reg == IDLE) && !bus.FLUSH;
  assign accept        = bus.REQ_VALID && bus.REQ_READY;
  assign fill          = (state_reg == MISS_WAIT) && bus.LOOKUP_COMPLETE;
  // A flush anywhere between miss acceptance and the fill edge makes the returned entry stale.
  assign fill_keep     = fill && !flush_seen_reg && !bus.FLUSH;

  assign bus.RESP_VALID  = resp_valid_reg;
  assign bus.RESP_HIT    = resp_hit_reg;
  assign bus.RESP_PADDR  = resp_paddr_reg;
  assign bus.LOOKUP_RQST = lookup_rqst_reg;
  assign bus.LOOKUP_ADDR = lookup_addr_reg;

  assign unused_return_bits = ^bus.LOOKUP_RETURN[2:0];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg       <= IDLE;
      vaddr_reg       <= '0;
      flush_seen_reg  <= 1'b0;
      resp_valid_reg  <= 1'b0;
      resp_hit_reg    <= 1'b0;
      resp_paddr_reg  <= '0;
      lookup_rqst_reg <= 1'b0;
      lookup_addr_reg <= '0;
    end else begin
      resp_valid_reg  <= 1'b0;
      lookup_rqst_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (accept) begin
            if (hit_any) begin
              state_reg      <= RESP;
              resp_valid_reg <= 1'b1;
              resp_hit_reg   <= 1'b1;
              resp_paddr_reg <= {hit_ppn, bus.REQ_VADDR[2:0]};
            end else begin
              state_reg       <= MISS_REQ;
              vaddr_reg       <= bus.REQ_VADDR;
              flush_seen_reg  <= 1'b0;
              lookup_rqst_reg <= 1'b1;
              lookup_addr_reg <= bus.REQ_VADDR[8:3];
            end
          end
        end
        MISS_REQ: begin
          state_reg <= MISS_WAIT;
          if (bus.FLUSH) begin
            flush_seen_reg <= 1'b1;
          end
        end
        MISS_WAIT: begin
          if (fill) begin
            state_reg      <= RESP;
            resp_valid_reg <= 1'b1;
            resp_hit_reg   <= 1'b0;
            resp_paddr_reg <= {bus.LOOKUP_RETURN[11:3], vaddr_reg[2:0]};
          end else if (bus.FLUSH) begin
            flush_seen_reg <= 1'b1;
          end
        end
        RESP: begin
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  // Valid bits and the round-robin pointer; the pointer advances on every kept fill,
  // regardless of whether the victim slot was valid.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_reg      <= '0;
      victim_ptr_reg <= '0;
    end else if (bus.FLUSH) begin
      valid_reg      <= '0;
      victim_ptr_reg <= '0;
    end else if (fill_keep) begin
      valid_reg[victim_ptr_reg] <= 1'b1;
      victim_ptr_reg            <= victim_ptr_reg + PTR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (fill_keep) begin
      vpn_reg[victim_ptr_reg] <= vaddr_reg[8:3];
      ppn_reg[victim_ptr_reg] <= bus.LOOKUP_RETURN[11:3];
    end
  end

`ifdef TLB_STATS_EN
  logic [15:0] hit_count_reg;
  logic [15:0] miss_count_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hit_count_reg  <= '0;
      miss_count_reg <= '0;
    end else if (state_reg == RESP) begin
      if (resp_hit_reg) begin
        if (hit_count_reg != 16'hFFFF) begin
          hit_count_reg <= hit_count_reg + 16'd1;
        end
      end else begin
        if (miss_count_reg != 16'hFFFF) begin
          miss_count_reg <= miss_count_reg + 16'd1;
        end
      end
    end
  end

  assign HIT_COUNT  = hit_count_reg;
  assign MISS_COUNT = miss_count_reg;
`endif

endmodule

// File: tb/tb_tlb_8e.sv
// Bench for tlb_8e: directed vector table, hand sequences for reset/flush corners,
// and randomized traffic checked against an entry-list reference model.
module tb_tlb_8e;
  localparam int NE = 8;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  tlb_8e_if bus ();

`ifdef TLB_STATS_EN
  logic [15:0] hit_count;
  logic [15:0] miss_count;
`endif

  tlb_8e #(.NUM_ENTRIES(NE)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef TLB_STATS_EN
    ,
    .HIT_COUNT  (hit_count),
    .MISS_COUNT (miss_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic [8:0]  va;
    logic [11:0] ret;
    int          d;
    int          fmode;  // 0 none, 1 flush with request, 2 flush in MISS_WAIT, 3 flush on fill edge
    logic        exp_hit;
    logic [11:0] exp_pa;
  } vec_t;

  vec_t tbl [20];

  // Reference model: list of translations plus the next slot to overwrite.
  logic       m_valid [NE];
  logic [5:0] m_vpn   [NE];
  logic [8:0] m_ppn   [NE];
  int         m_vp;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic model_flush();
    for (int i = 0; i < NE; i++) m_valid[i] = 1'b0;
    m_vp = 0;
  endtask

  task automatic model_req(input logic [8:0] va, input logic [11:0] ret, input int fmode,
                           output logic ehit, output logic [11:0] epa);
    if (fmode == 1) model_flush();
    ehit = 1'b0;
    epa  = {ret[11:3], va[2:0]};
    for (int i = 0; i < NE; i++) begin
      if (m_valid[i] && m_vpn[i] == va[8:3]) begin
        ehit = 1'b1;
        epa  = {m_ppn[i], va[2:0]};
      end
    end
    if (!ehit) begin
      if (fmode >= 2) begin
        model_flush();
      end else begin
        m_valid[m_vp] = 1'b1;
        m_vpn[m_vp]   = va[8:3];
        m_ppn[m_vp]   = ret[11:3];
        m_vp          = (m_vp + 1) % NE;
      end
    end
  endtask

  task automatic idle_inputs();
    bus.REQ_VALID       = 1'b0;
    bus.REQ_VADDR       = '0;
    bus.FLUSH           = 1'b0;
    bus.LOOKUP_COMPLETE = 1'b0;
    bus.LOOKUP_RETURN   = '0;
  endtask

  task automatic do_reset(input logic check_outputs);
    @(negedge clk);
    rst_n = 1'b0;
    idle_inputs();
    repeat (3) @(negedge clk);
    if (check_outputs) begin
      chk("rst_ready", bus.REQ_READY, 0);
      chk("rst_resp_valid", bus.RESP_VALID, 0);
      chk("rst_resp_paddr", bus.RESP_PADDR, 0);
      chk("rst_resp_hit", bus.RESP_HIT, 0);
      chk("rst_lookup_rqst", bus.LOOKUP_RQST, 0);
      chk("rst_lookup_addr", bus.LOOKUP_ADDR, 0);
    end
    rst_n = 1'b1;
    model_flush();
    @(negedge clk);
  endtask

  // Issues one request and plays the page table; returns at the negedge after the response.
  task automatic xact(input logic [8:0] va, input logic [11:0] ret, input int d, input int fmode,
                      output logic seen, output logic hit, output logic [11:0] pa,
                      output int nrq, output logic [5:0] la, output int rq_at, output int rcyc);
    seen = 1'b0; hit = 1'b0; pa = '0; nrq = 0; la = '0; rq_at = -1; rcyc = -1;
    bus.REQ_VALID     = 1'b1;
    bus.REQ_VADDR     = va;
    bus.LOOKUP_RETURN = ret;
    if (fmode == 1) begin
      bus.FLUSH = 1'b1;
      #1;
      chk("ready_with_flush", bus.REQ_READY, 0);
      @(negedge clk);
      bus.FLUSH = 1'b0;
      #1;
    end
    chk("ready", bus.REQ_READY, 1);
    @(negedge clk);
    bus.REQ_VALID = 1'b0;
    for (int cyc = 0; cyc < 60 && !seen; cyc++) begin
      bus.LOOKUP_COMPLETE = 1'b0;
      bus.FLUSH           = 1'b0;
      if (bus.LOOKUP_RQST) begin
        nrq++;
        la = bus.LOOKUP_ADDR;
        if (rq_at < 0) rq_at = cyc;
      end
      if (bus.RESP_VALID) begin
        seen = 1'b1;
        hit  = bus.RESP_HIT;
        pa   = bus.RESP_PADDR;
        rcyc = cyc;
      end else begin
        if (rq_at >= 0 && cyc == rq_at + d) bus.LOOKUP_COMPLETE = 1'b1;
        if (rq_at >= 0 && ((fmode == 2 && cyc == rq_at + 1) || (fmode == 3 && cyc == rq_at + d)))
          bus.FLUSH = 1'b1;
        @(negedge clk);
      end
    end
    bus.LOOKUP_COMPLETE = 1'b0;
    bus.FLUSH           = 1'b0;
    @(negedge clk);
  endtask

  task automatic run_and_check(input int idx, input logic [8:0] va, input logic [11:0] ret,
                               input int d, input int fmode, input logic ehit, input logic [11:0] epa);
    logic seen, hit;
    logic [11:0] pa;
    logic [5:0] la;
    int nrq, rq_at, rcyc;
    xact(va, ret, d, fmode, seen, hit, pa, nrq, la, rq_at, rcyc);
    $display("xact %0d va=%h ret=%h fmode=%0d hit=%b pa=%h rqst=%0d", idx, va, ret, fmode, hit, pa, nrq);
    chk($sformatf("resp_seen[%0d]", idx), seen, 1);
    chk($sformatf("resp_hit[%0d]", idx), hit, ehit);
    chk($sformatf("resp_paddr[%0d]", idx), pa, epa);
    if (ehit) begin
      chk($sformatf("rqst_count[%0d]", idx), nrq, 0);
      chk($sformatf("hit_latency[%0d]", idx), rcyc, 0);
    end else begin
      chk($sformatf("rqst_count[%0d]", idx), nrq, 1);
      chk($sformatf("rqst_cycle[%0d]", idx), rq_at, 0);
      chk($sformatf("lookup_addr[%0d]", idx), la, va[8:3]);
      chk($sformatf("miss_latency[%0d]", idx), rcyc, d + 1);
    end
  endtask

  initial begin
    logic ehit;
    logic [11:0] epa;
    logic [8:0] va;
    logic [11:0] ret;
    int d, fmode, r;
    logic any_resp, any_rqst;

    errors = 0;
    checks = 0;
    rst_n  = 1'b0;
    idle_inputs();
    model_flush();

    tbl[0] = '{9'h0A5, 12'h3B8, 2, 0, 1'b0, 12'h3BD};
    tbl[1] = '{9'h0A3, 12'h000, 2, 0, 1'b1, 12'h3BB};
    for (int v = 0; v <= 8; v++)
      tbl[2 + v] = '{9'((v << 3) | 5), 12'(12'h100 + 8 * v), 2, (v == 0) ? 1 : 0,
                     1'b0, 12'(12'h105 + 8 * v)};
    tbl[11] = '{9'h00D, 12'h000, 2, 0, 1'b1, 12'h10D};
    tbl[12] = '{9'h005, 12'h7F8, 2, 0, 1'b0, 12'h7FD};
    tbl[13] = '{9'h045, 12'h000, 2, 0, 1'b1, 12'h145};
    tbl[14] = '{9'h182, 12'hAA8, 3, 2, 1'b0, 12'hAAA};
    tbl[15] = '{9'h182, 12'hBB0, 2, 0, 1'b0, 12'hBB2};
    tbl[16] = '{9'h187, 12'h000, 2, 0, 1'b1, 12'hBB7};
    tbl[17] = '{9'h1C1, 12'h5A0, 2, 3, 1'b0, 12'h5A1};
    tbl[18] = '{9'h1C1, 12'h660, 1, 0, 1'b0, 12'h661};
    tbl[19] = '{9'h182, 12'h008, 2, 0, 1'b0, 12'h00A};

    do_reset(1'b1);
    chk("ready_after_reset", bus.REQ_READY, 1);

    for (int i = 0; i < 20; i++)
      run_and_check(i, tbl[i].va, tbl[i].ret, tbl[i].d, tbl[i].fmode, tbl[i].exp_hit, tbl[i].exp_pa);

    // Randomized traffic over a small VPN set so hits, wraps and flushes all occur.
    do_reset(1'b0);
    for (int i = 0; i < 150; i++) begin
      va  = {6'($urandom_range(0, 11)), 3'($urandom_range(0, 7))};
      ret = 12'($urandom);
      d   = $urandom_range(1, 4);
      r   = $urandom_range(0, 11);
      fmode = (r == 9) ? 1 : (r == 10) ? 2 : (r == 11) ? 3 : 0;
      model_req(va, ret, fmode, ehit, epa);
      run_and_check(100 + i, va, ret, d, fmode, ehit, epa);
    end

    // Reset during MISS_WAIT abandons the lookup; a late completion must be ignored.
    do_reset(1'b0);
    bus.REQ_VALID = 1'b1;
    bus.REQ_VADDR = 9'h0F0;
    bus.LOOKUP_RETURN = 12'h1F0;
    @(negedge clk);
    bus.REQ_VALID = 1'b0;
    chk("midreset_rqst", bus.LOOKUP_RQST, 1);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midreset_ready", bus.REQ_READY, 0);
    rst_n = 1'b1;
    bus.LOOKUP_COMPLETE = 1'b1;
    @(negedge clk);
    bus.LOOKUP_COMPLETE = 1'b0;
    any_resp = 1'b0;
    any_rqst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      if (bus.RESP_VALID) any_resp = 1'b1;
      if (bus.LOOKUP_RQST) any_rqst = 1'b1;
      @(negedge clk);
    end
    $display("xact midreset va=0f0 resp=%b rqst=%b", any_resp, any_rqst);
    chk("midreset_no_resp", any_resp, 0);
    chk("midreset_no_rqst", any_rqst, 0);
    model_flush();
    run_and_check(300, 9'h0F0, 12'h1F0, 2, 0, 1'b0, 12'h1F0);

`ifdef TLB_STATS_EN
    do_reset(1'b0);
    chk("hit_count_reset", hit_count, 0);
    chk("miss_count_reset", miss_count, 0);
    run_and_check(400, 9'h048, 12'h230, 2, 0, 1'b0, 12'h230);
    run_and_check(401, 9'h049, 12'h000, 2, 0, 1'b1, 12'h231);
    run_and_check(402, 9'h04A, 12'h000, 2, 0, 1'b1, 12'h232);
    run_and_check(403, 9'h050, 12'h448, 1, 0, 1'b0, 12'h448);
    run_and_check(404, 9'h051, 12'h000, 2, 0, 1'b1, 12'h449);
    chk("hit_count", hit_count, 3);
    chk("miss_count", miss_count, 2);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/tlb_8e.md
# tlb_8e

Eight-entry fully associative translation cache directly upstream of the 8-byte-page page table. It accepts 9-bit virtual addresses, answers hits from its own entries in one cycle, and on a miss issues a single lookup to the page table. It then installs the returned translation and answers the requester. Requesters see one request/response interface; the page table sees one outstanding lookup at most.

## Interface
- `NUM_ENTRIES`, 8: entry count; power of two, 2..8.
- `clk` in 1: single clock, all logic on rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `REQ_VALID` in 1: translation request present.
- `REQ_VADDR` in 9: virtual address; VPN = [8:3], offset = [2:0].
- `REQ_READY` out 1: request accepted on an edge where `REQ_VALID && REQ_READY`.
- `RESP_VALID` out 1: one-cycle response pulse.
- `RESP_PADDR` out 12: `{PPN[8:0], offset[2:0]}`.
- `RESP_HIT` out 1: 1 = served from TLB; 0 = served via page table.
- `FLUSH` in 1: invalidate all entries.
- `LOOKUP_RQST` out 1: page-table request, one-cycle pulse.
- `LOOKUP_ADDR` out 6: VPN for the page-table request.
- `LOOKUP_COMPLETE` in 1: page-table done, sampled high on a rising edge.
- `LOOKUP_RETURN` in 12: translation; `[11:3]` = PPN, `[2:0]` ignored.

## Operation
- Each entry holds a valid bit, a 6-bit VPN and a 9-bit PPN.
- The FSM has four states: IDLE, MISS_REQ, MISS_WAIT and RESP.
- `REQ_READY = (state==IDLE) && !FLUSH`.
- IDLE with a request accepted:
  - Tags are compared combinationally against `REQ_VADDR[8:3]`. Valid entries with distinct VPNs are guaranteed, so at most one entry matches.
  - Hit: register the PPN, go to RESP with `RESP_HIT=1`.
  - Miss: latch vaddr, go to MISS_REQ.
- MISS_REQ: drive `LOOKUP_RQST=1` and `LOOKUP_ADDR=vpn` for exactly one cycle, then go to MISS_WAIT.
- MISS_WAIT: hold `LOOKUP_ADDR`, keep `LOOKUP_RQST=0`, and wait for `LOOKUP_COMPLETE`.
  - On completion, write `{1, vpn, LOOKUP_RETURN[11:3]}` into the entry at `victim_ptr`.
  - Increment `victim_ptr` modulo `NUM_ENTRIES` (wraps from 7 to 0).
  - Go to RESP with `RESP_HIT=0`.
- RESP: `RESP_VALID=1` for one cycle, then IDLE. There is no backpressure; the requester must take the response.
- Replacement is round-robin over all slots. Invalid slots are not preferred.
- `LOOKUP_COMPLETE` outside MISS_WAIT is ignored.
- `FLUSH`:
  - Clears all valid bits at that edge; `victim_ptr` resets to 0.
  - If FLUSH is seen at any edge from miss acceptance up to and including the fill edge, the fill is discarded (no install, `victim_ptr` unchanged). The response is still delivered with `RESP_HIT=0`.
- Width rule: the PPN is truncated from 12 bits to `[11:3]`. `RESP_PADDR` is always 12 bits.

## Timing
- Reset values:
  - `REQ_READY=0` during reset; state = IDLE.
  - `RESP_VALID=0`, `RESP_PADDR=0`, `RESP_HIT=0`.
  - `LOOKUP_RQST=0`, `LOOKUP_ADDR=0`.
  - All valid bits 0, `victim_ptr=0`.
- Reset mid-miss abandons the lookup silently. A later `LOOKUP_COMPLETE` is ignored.
- Hit latency: accept at edge N, `RESP_VALID` high in cycle N+1, next accept possible at edge N+2.
- Miss latency: accept at edge N, `LOOKUP_RQST` high in cycle N+1. If complete is sampled at edge M (M ≥ N+2), `RESP_VALID` is high in cycle M+1.
- Throughput: one request per 2 cycles on hits.

## Configuration
- `TLB_STATS_EN` defined:
  - Adds outputs `HIT_COUNT[15:0]` and `MISS_COUNT[15:0]`.
  - Each increments at the RESP cycle of its type and saturates at 16'hFFFF.
  - Both cleared by reset only; FLUSH does not clear them.
- `TLB_STATS_EN` undefined: the ports and counters are absent.

## Test plan
- **Cold miss.** After reset, request vaddr 9'h0A5 (VPN 0x14); page table returns 12'h3B8 two cycles after the rqst pulse.
  - One `LOOKUP_RQST` pulse with `LOOKUP_ADDR=0x14`.
  - `RESP_PADDR=12'h3BD`, `RESP_HIT=0`.
- **Hit after fill.** Repeat 9'h0A3 → response in cycle N+1 with `RESP_PADDR=12'h3BB`, `RESP_HIT=1`, and no `LOOKUP_RQST`.
- **Wrap-around.** Miss on 9 distinct VPNs 0..8.
  - The 9th fill overwrites slot 0 (VPN 0).
  - A re-request of VPN 0 misses; VPN 1 still hits.
- **Flush during miss.** FLUSH one cycle while in MISS_WAIT.
  - Response is delivered with `RESP_HIT=0`.
  - A repeat of the same VPN misses again; `victim_ptr` is 0.
- **Simultaneous FLUSH and REQ_VALID in IDLE.** `REQ_READY=0` that cycle and the request is accepted on the next edge as a miss.
- **Reset mid-miss, then stats.**
  - Assert `rst_n=0` during MISS_WAIT, then pulse `LOOKUP_COMPLETE`: no `RESP_VALID`, no install.
  - With `TLB_STATS_EN`: after 3 hits and 2 misses, `HIT_COUNT=3` and `MISS_COUNT=2`.
